// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file with writeback bypass, load-use interlock
// with configurable load latency, downstream hold, branch flush and ID/EX register.
module decode_issue_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DAT_WIDTH  = 32,
  parameter int REG_AW     = 5,
  parameter int CTRL_W     = 8,
  parameter int LOAD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_d,
  input  logic [31:0]           ins_d,
  input  logic                  uses_rs1_d,
  input  logic                  uses_rs2_d,
  input  logic                  reg_write_d,
  input  logic                  mem_read_d,
  input  logic                  mem_write_d,
  input  logic [CTRL_W-1:0]     ctrl_d,
  input  logic [DAT_WIDTH-1:0]  imm_d,
  input  logic [ADDR_WIDTH-1:0] pc_d,
  input  logic [ADDR_WIDTH-1:0] pc4_d,
  input  logic                  reg_write_w,
  input  logic [REG_AW-1:0]     rd_w,
  input  logic [DAT_WIDTH-1:0]  result_w,
  input  logic                  hold_e,
  input  logic                  flush_e,
  output logic                  valid_e,
  output logic                  reg_write_e,
  output logic                  mem_read_e,
  output logic                  mem_write_e,
  output logic [CTRL_W-1:0]     ctrl_e,
  output logic [DAT_WIDTH-1:0]  imm_e,
  output logic [DAT_WIDTH-1:0]  rdata1_e,
  output logic [DAT_WIDTH-1:0]  rdata2_e,
  output logic [REG_AW-1:0]     rs1_e,
  output logic [REG_AW-1:0]     rs2_e,
  output logic [REG_AW-1:0]     rd_e,
  output logic [ADDR_WIDTH-1:0] pc_e,
  output logic [ADDR_WIDTH-1:0] pc4_e,
  output logic                  pc_write,
  output logic                  if_id_write
);

  localparam int         NREGS      = 1 << REG_AW;
  localparam logic [2:0] STALL_INIT = 3'(LOAD_LAT - 1);

  logic [DAT_WIDTH-1:0]  r_regs [NREGS];
  logic [2:0]            r_stall_cnt;
  logic                  r_valid_e;
  logic                  r_reg_write_e;
  logic                  r_mem_read_e;
  logic                  r_mem_write_e;
  logic [CTRL_W-1:0]     r_ctrl_e;
  logic [DAT_WIDTH-1:0]  r_imm_e;
  logic [DAT_WIDTH-1:0]  r_rdata1_e;
  logic [DAT_WIDTH-1:0]  r_rdata2_e;
  logic [REG_AW-1:0]     r_rs1_e;
  logic [REG_AW-1:0]     r_rs2_e;
  logic [REG_AW-1:0]     r_rd_e;
  logic [ADDR_WIDTH-1:0] r_pc_e;
  logic [ADDR_WIDTH-1:0] r_pc4_e;

  logic [REG_AW-1:0]     w_rs1;
  logic [REG_AW-1:0]     w_rs2;
  logic [REG_AW-1:0]     w_rd;
  logic                  w_wb_en;
  logic [DAT_WIDTH-1:0]  w_rdata1;
  logic [DAT_WIDTH-1:0]  w_rdata2;
  logic                  w_load_e;
  logic                  w_hazard;
  logic                  w_stall;
  logic                  w_unused;

  assign w_rs1    = ins_d[15 +: REG_AW];
  assign w_rs2    = ins_d[20 +: REG_AW];
  assign w_rd     = ins_d[7 +: REG_AW];
  assign w_unused = ^{ins_d, 1'b0};
  assign w_wb_en  = reg_write_w & (rd_w != {REG_AW{1'b0}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {DAT_WIDTH{1'b0}};
      end
    end else if (w_wb_en) begin
      r_regs[rd_w] <= result_w;
    end
  end

  // Writeback data is forwarded so a same-cycle write is seen by decode.
  always_comb begin
    w_rdata1 = {DAT_WIDTH{1'b0}};
    w_rdata2 = {DAT_WIDTH{1'b0}};
    if (w_rs1 == {REG_AW{1'b0}}) begin
      w_rdata1 = {DAT_WIDTH{1'b0}};
    end else if (w_wb_en && (rd_w == w_rs1)) begin
      w_rdata1 = result_w;
    end else begin
      w_rdata1 = r_regs[w_rs1];
    end
    if (w_rs2 == {REG_AW{1'b0}}) begin
      w_rdata2 = {DAT_WIDTH{1'b0}};
    end else if (w_wb_en && (rd_w == w_rs2)) begin
      w_rdata2 = result_w;
    end else begin
      w_rdata2 = r_regs[w_rs2];
    end
  end

  assign w_load_e = r_valid_e & r_mem_read_e & (r_rd_e != {REG_AW{1'b0}});
  assign w_hazard = w_load_e & valid_d &
                    ((uses_rs1_d & (w_rs1 == r_rd_e)) | (uses_rs2_d & (w_rs2 == r_rd_e)));
  assign w_stall  = w_hazard | (r_stall_cnt != 3'd0);

  assign pc_write    = ~(w_stall | hold_e);
  assign if_id_write = ~(w_stall | hold_e);

  // A bubble clears only control; data, address and PC fields keep their values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt   <= 3'd0;
      r_valid_e     <= 1'b0;
      r_reg_write_e <= 1'b0;
      r_mem_read_e  <= 1'b0;
      r_mem_write_e <= 1'b0;
      r_ctrl_e      <= {CTRL_W{1'b0}};
      r_imm_e       <= {DAT_WIDTH{1'b0}};
      r_rdata1_e    <= {DAT_WIDTH{1'b0}};
      r_rdata2_e    <= {DAT_WIDTH{1'b0}};
      r_rs1_e       <= {REG_AW{1'b0}};
      r_rs2_e       <= {REG_AW{1'b0}};
      r_rd_e        <= {REG_AW{1'b0}};
      r_pc_e        <= {ADDR_WIDTH{1'b0}};
      r_pc4_e       <= {ADDR_WIDTH{1'b0}};
    end else if (hold_e) begin
      r_stall_cnt <= r_stall_cnt;
    end else if (flush_e || w_stall) begin
      r_valid_e     <= 1'b0;
      r_reg_write_e <= 1'b0;
      r_mem_read_e  <= 1'b0;
      r_mem_write_e <= 1'b0;
      r_ctrl_e      <= {CTRL_W{1'b0}};
      if (flush_e) begin
        r_stall_cnt <= 3'd0;
      end else if (w_hazard) begin
        r_stall_cnt <= STALL_INIT;
      end else begin
        r_stall_cnt <= r_stall_cnt - 3'd1;
      end
    end else begin
      r_valid_e     <= valid_d;
      r_reg_write_e <= valid_d & reg_write_d;
      r_mem_read_e  <= valid_d & mem_read_d;
      r_mem_write_e <= valid_d & mem_write_d;
      r_ctrl_e      <= valid_d ? ctrl_d : {CTRL_W{1'b0}};
      r_imm_e       <= imm_d;
      r_rdata1_e    <= w_rdata1;
      r_rdata2_e    <= w_rdata2;
      r_rs1_e       <= w_rs1;
      r_rs2_e       <= w_rs2;
      r_rd_e        <= w_rd;
      r_pc_e        <= pc_d;
      r_pc4_e       <= pc4_d;
    end
  end

  assign valid_e     = r_valid_e;
  assign reg_write_e = r_reg_write_e;
  assign mem_read_e  = r_mem_read_e;
  assign mem_write_e = r_mem_write_e;
  assign ctrl_e      = r_ctrl_e;
  assign imm_e       = r_imm_e;
  assign rdata1_e    = r_rdata1_e;
  assign rdata2_e    = r_rdata2_e;
  assign rs1_e       = r_rs1_e;
  assign rs2_e       = r_rs2_e;
  assign rd_e        = r_rd_e;
  assign pc_e        = r_pc_e;
  assign pc4_e       = r_pc4_e;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: one instance with LOAD_LAT=1 and one
// with LOAD_LAT=3 share the same stimulus; each test checks the relevant one.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_d, uses_rs1_d, uses_rs2_d, reg_write_d, mem_read_d, mem_write_d;
  logic [31:0] ins_d, imm_d, pc_d, pc4_d, result_w;
  logic [7:0]  ctrl_d;
  logic        reg_write_w, hold_e, flush_e;
  logic [4:0]  rd_w;

  logic        o1_valid_e, o1_reg_write_e, o1_mem_read_e, o1_mem_write_e, o1_pc_write, o1_if_id_write;
  logic [7:0]  o1_ctrl_e;
  logic [31:0] o1_imm_e, o1_rdata1_e, o1_rdata2_e, o1_pc_e, o1_pc4_e;
  logic [4:0]  o1_rs1_e, o1_rs2_e, o1_rd_e;
  logic        o3_valid_e, o3_reg_write_e, o3_mem_read_e, o3_mem_write_e, o3_pc_write, o3_if_id_write;
  logic [7:0]  o3_ctrl_e;
  logic [31:0] o3_imm_e, o3_rdata1_e, o3_rdata2_e, o3_pc_e, o3_pc4_e;
  logic [4:0]  o3_rs1_e, o3_rs2_e, o3_rd_e;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_issue_stage #(.LOAD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .ins_d(ins_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .reg_write_d(reg_write_d),
    .mem_read_d(mem_read_d), .mem_write_d(mem_write_d), .ctrl_d(ctrl_d), .imm_d(imm_d),
    .pc_d(pc_d), .pc4_d(pc4_d), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .hold_e(hold_e), .flush_e(flush_e),
    .valid_e(o1_valid_e), .reg_write_e(o1_reg_write_e), .mem_read_e(o1_mem_read_e),
    .mem_write_e(o1_mem_write_e), .ctrl_e(o1_ctrl_e), .imm_e(o1_imm_e),
    .rdata1_e(o1_rdata1_e), .rdata2_e(o1_rdata2_e), .rs1_e(o1_rs1_e), .rs2_e(o1_rs2_e),
    .rd_e(o1_rd_e), .pc_e(o1_pc_e), .pc4_e(o1_pc4_e),
    .pc_write(o1_pc_write), .if_id_write(o1_if_id_write)
  );

  decode_issue_stage #(.LOAD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .ins_d(ins_d),
    .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d), .reg_write_d(reg_write_d),
    .mem_read_d(mem_read_d), .mem_write_d(mem_write_d), .ctrl_d(ctrl_d), .imm_d(imm_d),
    .pc_d(pc_d), .pc4_d(pc4_d), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .hold_e(hold_e), .flush_e(flush_e),
    .valid_e(o3_valid_e), .reg_write_e(o3_reg_write_e), .mem_read_e(o3_mem_read_e),
    .mem_write_e(o3_mem_write_e), .ctrl_e(o3_ctrl_e), .imm_e(o3_imm_e),
    .rdata1_e(o3_rdata1_e), .rdata2_e(o3_rdata2_e), .rs1_e(o3_rs1_e), .rs2_e(o3_rs2_e),
    .rd_e(o3_rd_e), .pc_e(o3_pc_e), .pc4_e(o3_pc4_e),
    .pc_write(o3_pc_write), .if_id_write(o3_if_id_write)
  );

  function automatic logic [31:0] enc(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    enc = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [31:0] ins, input logic u1, input logic u2,
                         input logic rw, input logic mr, input logic [7:0] ctrl,
                         input logic [31:0] imm, input logic [31:0] pc);
    valid_d = v; ins_d = ins; uses_rs1_d = u1; uses_rs2_d = u2;
    reg_write_d = rw; mem_read_d = mr; mem_write_d = 1'b0;
    ctrl_d = ctrl; imm_d = imm; pc_d = pc; pc4_d = pc + 32'd4;
  endtask

  task automatic settle;
    set_dec(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    reg_write_w = 1'b0; rd_w = 5'd0; result_w = 32'h0; hold_e = 1'b0; flush_e = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_dec(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
    reg_write_w = 1'b0; rd_w = 5'd0; result_w = 32'h0; hold_e = 1'b0; flush_e = 1'b0;
    repeat (2) tick();
    n_vec++; if (o1_valid_e !== 1'b0) begin n_err++; $display("FAIL reset_valid_e: got %0h want 0", o1_valid_e); end
    n_vec++; if (o1_pc_e !== 32'h0) begin n_err++; $display("FAIL reset_pc_e: got %0h want 0", o1_pc_e); end
    n_vec++; if (o1_ctrl_e !== 8'h00) begin n_err++; $display("FAIL reset_ctrl_e: got %0h want 0", o1_ctrl_e); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (o1_pc_write !== 1'b1) begin n_err++; $display("FAIL reset_pc_write: got %0h want 1", o1_pc_write); end
    n_vec++; if (o3_if_id_write !== 1'b1) begin n_err++; $display("FAIL reset_if_id_write: got %0h want 1", o3_if_id_write); end
  endtask

  task automatic test_basic;
    set_dec(1'b1, enc(5'd3, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 32'h11, 32'h100);
    tick();
    n_vec++; if (o1_valid_e !== 1'b1) begin n_err++; $display("FAIL basic_valid_e: got %0h want 1", o1_valid_e); end
    n_vec++; if (o1_rdata1_e !== 32'h0) begin n_err++; $display("FAIL basic_rdata1: got %0h want 0", o1_rdata1_e); end
    n_vec++; if (o1_rdata2_e !== 32'h0) begin n_err++; $display("FAIL basic_rdata2: got %0h want 0", o1_rdata2_e); end
    n_vec++; if (o1_rd_e !== 5'd3) begin n_err++; $display("FAIL basic_rd_e: got %0h want 3", o1_rd_e); end
    n_vec++; if (o1_pc_e !== 32'h100) begin n_err++; $display("FAIL basic_pc_e: got %0h want 100", o1_pc_e); end
    n_vec++; if (o1_pc4_e !== 32'h104) begin n_err++; $display("FAIL basic_pc4_e: got %0h want 104", o1_pc4_e); end
    n_vec++; if (o1_ctrl_e !== 8'h5A) begin n_err++; $display("FAIL basic_ctrl_e: got %0h want 5a", o1_ctrl_e); end
    n_vec++; if (o1_imm_e !== 32'h11) begin n_err++; $display("FAIL basic_imm_e: got %0h want 11", o1_imm_e); end
    n_vec++; if ({o1_rs1_e, o1_rs2_e} !== {5'd1, 5'd2}) begin n_err++; $display("FAIL basic_rs: got %0h/%0h want 1/2", o1_rs1_e, o1_rs2_e); end
    n_vec++; if (o1_reg_write_e !== 1'b1) begin n_err++; $display("FAIL basic_reg_write_e: got %0h want 1", o1_reg_write_e); end
  endtask

  task automatic test_bypass;
    reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'hDEADBEEF;
    set_dec(1'b1, enc(5'd7, 5'd5, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 32'h0, 32'h110);
    tick();
    n_vec++; if (o1_rdata1_e !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_x5: got %0h want deadbeef", o1_rdata1_e); end
    reg_write_w = 1'b1; rd_w = 5'd0; result_w = 32'h12345678;
    set_dec(1'b1, enc(5'd7, 5'd0, 5'd5), 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 32'h0, 32'h114);
    tick();
    n_vec++; if (o1_rdata1_e !== 32'h0) begin n_err++; $display("FAIL bypass_x0: got %0h want 0", o1_rdata1_e); end
    n_vec++; if (o1_rdata2_e !== 32'hDEADBEEF) begin n_err++; $display("FAIL stored_x5: got %0h want deadbeef", o1_rdata2_e); end
    reg_write_w = 1'b0;
    tick();
    n_vec++; if (o1_rdata1_e !== 32'h0) begin n_err++; $display("FAIL x0_kept_zero: got %0h want 0", o1_rdata1_e); end
    reg_write_w = 1'b1; rd_w = 5'd5; result_w = 32'hCAFEF00D;
    set_dec(1'b1, enc(5'd7, 5'd5, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 32'h0, 32'h118);
    tick();
    n_vec++; if (o1_rdata1_e !== 32'hCAFEF00D) begin n_err++; $display("FAIL bypass_over_stale: got %0h want cafef00d", o1_rdata1_e); end
    reg_write_w = 1'b0;
  endtask

  task automatic test_load_use_1;
    settle();
    set_dec(1'b1, enc(5'd6, 5'd1, 5'd0), 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 32'h0, 32'h200);
    tick();
    set_dec(1'b1, enc(5'd8, 5'd1, 5'd6), 1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 32'h0, 32'h204);
    #1;
    n_vec++; if ({o1_pc_write, o1_if_id_write} !== 2'b00) begin n_err++; $display("FAIL lu1_stall: got %0b want 00", {o1_pc_write, o1_if_id_write}); end
    tick();
    n_vec++; if (o1_valid_e !== 1'b0) begin n_err++; $display("FAIL lu1_bubble: got %0h want 0", o1_valid_e); end
    #1;
    n_vec++; if (o1_pc_write !== 1'b1) begin n_err++; $display("FAIL lu1_release: got %0h want 1", o1_pc_write); end
    tick();
    n_vec++; if ({o1_valid_e, o1_rd_e} !== {1'b1, 5'd8}) begin n_err++; $display("FAIL lu1_issue: got %0h/%0h want 1/8", o1_valid_e, o1_rd_e); end
    settle();
    set_dec(1'b1, enc(5'd6, 5'd1, 5'd0), 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 32'h0, 32'h300);
    tick();
    set_dec(1'b1, enc(5'd8, 5'd1, 5'd6), 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 32'h0, 32'h304);
    #1;
    n_vec++; if (o1_pc_write !== 1'b1) begin n_err++; $display("FAIL lu1_no_rs2_use: got %0h want 1", o1_pc_write); end
    tick();
    n_vec++; if (o1_valid_e !== 1'b1) begin n_err++; $display("FAIL lu1_no_stall_issue: got %0h want 1", o1_valid_e); end
  endtask

  task automatic test_load_use_3;
    settle();
    set_dec(1'b1, enc(5'd6, 5'd1, 5'd0), 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 32'h0, 32'h400);
    tick();
    set_dec(1'b1, enc(5'd8, 5'd1, 5'd6), 1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 32'h0, 32'h404);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (o3_pc_write !== 1'b0) begin n_err++; $display("FAIL lu3_stall_%0d: got %0h want 0", k, o3_pc_write); end
      tick();
      n_vec++; if (o3_valid_e !== 1'b0) begin n_err++; $display("FAIL lu3_bubble_%0d: got %0h want 0", k, o3_valid_e); end
    end
    #1;
    n_vec++; if (o3_pc_write !== 1'b1) begin n_err++; $display("FAIL lu3_release: got %0h want 1", o3_pc_write); end
    tick();
    n_vec++; if ({o3_valid_e, o3_rd_e} !== {1'b1, 5'd8}) begin n_err++; $display("FAIL lu3_issue: got %0h/%0h want 1/8", o3_valid_e, o3_rd_e); end
  endtask

  task automatic test_hold_flush;
    settle();
    set_dec(1'b1, enc(5'd9, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 32'h55, 32'h500);
    tick();
    hold_e = 1'b1; flush_e = 1'b1;
    set_dec(1'b1, enc(5'd10, 5'd3, 5'd4), 1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 32'h66, 32'h600);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++; if ({o1_pc_write, o1_if_id_write} !== 2'b00) begin n_err++; $display("FAIL hold_pc_write_%0d: got %0b want 00", k, {o1_pc_write, o1_if_id_write}); end
      tick();
      n_vec++; if ({o1_valid_e, o1_ctrl_e, o1_rd_e} !== {1'b1, 8'h3C, 5'd9}) begin n_err++; $display("FAIL hold_ctrl_%0d: got %0h/%0h/%0h want 1/3c/9", k, o1_valid_e, o1_ctrl_e, o1_rd_e); end
      n_vec++; if ({o1_pc_e, o1_imm_e} !== {32'h500, 32'h55}) begin n_err++; $display("FAIL hold_data_%0d: got %0h/%0h want 500/55", k, o1_pc_e, o1_imm_e); end
    end
    hold_e = 1'b0;
    tick();
    n_vec++; if ({o1_valid_e, o1_reg_write_e} !== 2'b00) begin n_err++; $display("FAIL flush_ctrl: got %0b want 00", {o1_valid_e, o1_reg_write_e}); end
    n_vec++; if (o1_pc_e !== 32'h500) begin n_err++; $display("FAIL flush_keeps_pc: got %0h want 500", o1_pc_e); end
    flush_e = 1'b0;
  endtask

  task automatic test_flush_in_stall;
    settle();
    set_dec(1'b1, enc(5'd6, 5'd1, 5'd0), 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 32'h0, 32'h700);
    tick();
    set_dec(1'b1, enc(5'd8, 5'd6, 5'd2), 1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 32'h0, 32'h704);
    tick();
    flush_e = 1'b1;
    #1;
    n_vec++; if (o3_pc_write !== 1'b0) begin n_err++; $display("FAIL fs_still_stalled: got %0h want 0", o3_pc_write); end
    tick();
    flush_e = 1'b0;
    n_vec++; if (o3_valid_e !== 1'b0) begin n_err++; $display("FAIL fs_bubble: got %0h want 0", o3_valid_e); end
    #1;
    n_vec++; if (o3_pc_write !== 1'b1) begin n_err++; $display("FAIL fs_counter_cleared: got %0h want 1", o3_pc_write); end
    tick();
    n_vec++; if ({o3_valid_e, o3_pc_e} !== {1'b1, 32'h704}) begin n_err++; $display("FAIL fs_issue: got %0h/%0h want 1/704", o3_valid_e, o3_pc_e); end
  endtask

  task automatic test_reset_mid_stall;
    settle();
    set_dec(1'b1, enc(5'd6, 5'd1, 5'd0), 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 32'h0, 32'h800);
    tick();
    set_dec(1'b1, enc(5'd8, 5'd6, 5'd2), 1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 32'h0, 32'h804);
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++; if ({o3_valid_e, o3_pc_write} !== 2'b01) begin n_err++; $display("FAIL rst_abort_stall: got %0b want 01", {o3_valid_e, o3_pc_write}); end
    rst_n = 1'b1;
    tick();
    n_vec++; if ({o3_valid_e, o3_rd_e, o3_pc_e} !== {1'b1, 5'd8, 32'h804}) begin n_err++; $display("FAIL rst_first_issue: got %0h/%0h/%0h want 1/8/804", o3_valid_e, o3_rd_e, o3_pc_e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_load_use_1();
    test_load_use_3();
    test_hold_flush();
    test_flush_in_stall();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
